surf_event_sequencer: RTL and testbench
=======================================

Name: surf_event_sequencer

Overview:
- Sequences per-SURF event streams (one spliced, buffered 8-bit AXI4-stream per SURF, tlast on each event's final byte) into a single event stream for downstream event building.
- Per event, drains SURF 0 to NSURF-1 in fixed order, one complete event per SURF, then moves to the next event.
- Masked SURFs already supply fake events upstream, so every input always delivers exactly one event per trigger.
- Detects stalled SURFs (timeout) and wrong-length segments; reports both as sticky errors.

Parameters:
- NSURF, 7, number of SURF input streams.
- SEG_BYTES, 12292, required bytes per SURF event segment (8 ch × 1536 + 4 header).
- TIMEOUT_WIDTH, 24, width of stall timeout counter and timeout_i.

Ports:
- aclk  in  1  clock
- aresetn  in  1  synchronous active-low reset
- s_dout_tdata  in  8*NSURF  per-SURF data, SURF i in bits [8i+7:8i]
- s_dout_tvalid  in  NSURF  per-SURF valid
- s_dout_tlast  in  NSURF  per-SURF end of event
- s_dout_tready  out  NSURF  per-SURF ready
- m_dout_tdata  out  8  merged data
- m_dout_tvalid  out  1  merged valid
- m_dout_tready  in  1  merged ready
- m_dout_tlast  out  1  last byte of the whole event (last byte of SURF NSURF-1)
- timeout_i  in  TIMEOUT_WIDTH  stall limit in aclk cycles; 0 disables
- err_clear_i  in  1  clears sticky errors
- cur_surf_o  out  $clog2(NSURF)  SURF currently selected
- busy_o  out  1  high when not IDLE
- event_count_o  out  16  completed events, wraps at 65535 → 0
- err_timeout_o  out  1  sticky stall error
- err_length_o  out  1  sticky segment-length error

Behaviour:
- Reset (aresetn low at a clock edge):
  - state = IDLE, sel = 0
  - byte counter, stall counter and event_count_o = 0
  - both error flags = 0
  - all s_dout_tready = 0, m_dout_tvalid = 0
  - A mid-event reset abandons the event. Partial input data is not flushed; upstream resets from the same aresetn.
- States:
  - IDLE: sel = 0. Go to STREAM when s_dout_tvalid[0] = 1. No data is transferred in IDLE.
  - STREAM: combinational pass-through, zero latency:
    - m_dout_tdata = s_dout_tdata[sel], m_dout_tvalid = s_dout_tvalid[sel]
    - s_dout_tready[sel] = m_dout_tready; all other tready = 0
    - m_dout_tlast = s_dout_tlast[sel] && sel == NSURF-1
    - Handshake = m_dout_tvalid && m_dout_tready.
    - Handshake with s_dout_tlast[sel] and sel < NSURF-1: sel increments next cycle; state stays STREAM; byte counter reset.
    - Same with sel == NSURF-1: go to DONE.
  - DONE: one cycle, all tready = 0, m_dout_tvalid = 0. Increment event_count_o, go to IDLE.
- Length check:
  - Byte counter increments on each handshake; a segment ends on the handshake with s_dout_tlast[sel].
  - If the count at that point (including the tlast byte) ≠ SEG_BYTES, set err_length_o. Sequencing continues normally.
  - If the count reaches SEG_BYTES without tlast, set err_length_o and keep forwarding until tlast. The counter saturates at its maximum.
- Stall timeout:
  - Active only in STREAM with timeout_i ≠ 0.
  - The counter increments each cycle that s_dout_tvalid[sel] = 0. It resets on any cycle with s_dout_tvalid[sel] = 1, and on a sel change.
  - When the counter equals timeout_i, set err_timeout_o. Counter holds; no data is dropped; the block keeps waiting.
  - Backpressure (valid high, ready low) does not count as a stall.
- Errors:
  - err_clear_i clears both flags in the same cycle.
  - If a set condition and err_clear_i occur together, the set wins.
- Outputs:
  - cur_surf_o = sel.
  - busy_o = (state ≠ IDLE), registered from state.

Test Plan:
- NSURF=7, each input preloaded with one 12292-byte event, m_dout_tready = 1:
  - output is 86044 bytes in SURF order 0..6;
  - m_dout_tlast only on byte 86044;
  - event_count_o 0 → 1 one cycle after that byte;
  - no errors.
- Same stimulus with m_dout_tready toggled randomly: identical byte sequence; no duplicated or lost bytes; each tready only asserted for cur_surf_o.
- SURF 3 delivers 12291 bytes then tlast: err_length_o = 1 after its tlast handshake; sequencing continues with SURF 4; event completes. Then err_clear_i → err_length_o = 0.
- timeout_i = 100, SURF 2 tvalid held low 150 cycles mid-segment:
  - err_timeout_o rises on the 100th idle cycle;
  - data resumes and the event completes correctly.
- timeout_i = 0, same stall: err_timeout_o stays 0.
- Set event_count_o to 65535 by running 65535 events (or a force), then one more event: event_count_o = 0.
- aresetn low for one cycle while SURF 4 is mid-segment: all outputs at reset values next cycle; sel = 0; busy_o = 0.

Source files
------------

// File: rtl/surf_event_sequencer_if.sv
// Per-SURF input byte streams and the merged output stream of the event sequencer.
interface surf_event_sequencer_if #(
    parameter int NSURF = 7
);
    logic [8*NSURF-1:0] s_dout_tdata;
    logic [NSURF-1:0]   s_dout_tvalid;
    logic [NSURF-1:0]   s_dout_tlast;
    logic [NSURF-1:0]   s_dout_tready;
    logic [7:0]         m_dout_tdata;
    logic               m_dout_tvalid;
    logic               m_dout_tready;
    logic               m_dout_tlast;

    modport slave (
        input  s_dout_tdata, s_dout_tvalid, s_dout_tlast,
        output s_dout_tready,
        output m_dout_tdata, m_dout_tvalid, m_dout_tlast,
        input  m_dout_tready
    );

    modport master (
        output s_dout_tdata, s_dout_tvalid, s_dout_tlast,
        input  s_dout_tready,
        input  m_dout_tdata, m_dout_tvalid, m_dout_tlast,
        output m_dout_tready
    );
endinterface

// File: rtl/surf_event_sequencer.sv
// Merges per-SURF event segments into one event stream, SURF 0..NSURF-1 in order,
// with sticky stall-timeout and segment-length error reporting.
module surf_event_sequencer #(
    parameter int NSURF         = 7,
    parameter int SEG_BYTES     = 12292,
    parameter int TIMEOUT_WIDTH = 24,
    localparam int SEL_W        = $clog2(NSURF)
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    surf_event_sequencer_if.slave    dout,
    input  logic [TIMEOUT_WIDTH-1:0] timeout_i,
    input  logic                     err_clear_i,
    output logic [SEL_W-1:0]         cur_surf_o,
    output logic                     busy_o,
    output logic [15:0]              event_count_o,
    output logic                     err_timeout_o,
    output logic                     err_length_o
);
    localparam int CNT_W = $clog2(SEG_BYTES + 1);
    localparam logic [CNT_W-1:0] SEG_LEN = CNT_W'(SEG_BYTES);
    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NSURF - 1);

    typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

    state_t                   state, state_nxt;
    logic [SEL_W-1:0]         sel;
    logic [CNT_W-1:0]         byte_cnt, byte_cnt_inc;
    logic [TIMEOUT_WIDTH-1:0] stall_cnt, stall_nxt;
    logic [15:0]              event_cnt;
    logic                     busy_q, err_to_q, err_len_q;

    logic       sel_valid, sel_last, last_surf, hs, seg_end;
    logic       stall_active, len_err, to_err;
    logic [7:0] sel_data;

    assign sel_valid = dout.s_dout_tvalid[sel];
    assign sel_last  = dout.s_dout_tlast[sel];
    assign sel_data  = dout.s_dout_tdata[8*sel +: 8];
    assign last_surf = (sel == LAST_SEL);
    assign hs        = (state == STREAM) && sel_valid && dout.m_dout_tready;
    assign seg_end   = hs && sel_last;

    // Saturating so an over-long segment cannot wrap back onto SEG_LEN.
    assign byte_cnt_inc = (&byte_cnt) ? byte_cnt : byte_cnt + CNT_W'(1);
    assign len_err = seg_end ? (byte_cnt_inc != SEG_LEN)
                             : (hs && byte_cnt_inc == SEG_LEN);

    assign stall_active = (state == STREAM) && (timeout_i != '0);

    always_comb begin
        stall_nxt = stall_cnt;
        if (!stall_active || sel_valid)
            stall_nxt = '0;
        else if (stall_cnt != timeout_i)
            stall_nxt = stall_cnt + TIMEOUT_WIDTH'(1);
    end

    assign to_err = stall_active && !sel_valid && (stall_nxt == timeout_i);

    always_ff @(posedge aclk) begin
        if (!aresetn) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (dout.s_dout_tvalid[0]) state_nxt = STREAM;
            STREAM:  if (seg_end && last_surf) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        dout.m_dout_tdata  = '0;
        dout.m_dout_tvalid = 1'b0;
        dout.m_dout_tlast  = 1'b0;
        dout.s_dout_tready = '0;
        if (state == STREAM) begin
            dout.m_dout_tdata       = sel_data;
            dout.m_dout_tvalid      = sel_valid;
            dout.m_dout_tlast       = sel_last && last_surf;
            dout.s_dout_tready[sel] = dout.m_dout_tready;
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            sel       <= '0;
            byte_cnt  <= '0;
            stall_cnt <= '0;
            event_cnt <= '0;
            busy_q    <= 1'b0;
            err_to_q  <= 1'b0;
            err_len_q <= 1'b0;
        end else begin
            stall_cnt <= stall_nxt;
            busy_q    <= (state_nxt != IDLE);

            if (state != STREAM)
                sel <= '0;
            else if (seg_end && !last_surf)
                sel <= sel + SEL_W'(1);

            if (state != STREAM || seg_end) byte_cnt <= '0;
            else if (hs)                    byte_cnt <= byte_cnt_inc;

            if (state == DONE) event_cnt <= event_cnt + 16'd1;

            // A fresh error in the clearing cycle must not be lost.
            if (len_err)          err_len_q <= 1'b1;
            else if (err_clear_i) err_len_q <= 1'b0;
            if (to_err)           err_to_q  <= 1'b1;
            else if (err_clear_i) err_to_q  <= 1'b0;
        end
    end

    assign cur_surf_o    = sel;
    assign busy_o        = busy_q;
    assign event_count_o = event_cnt;
    assign err_timeout_o = err_to_q;
    assign err_length_o  = err_len_q;
endmodule

// File: tb/tb_surf_event_sequencer.sv
// Directed bench: SURF source models feed the sequencer; output bytes are checked against an expected stream.
module tb_surf_event_sequencer;
    localparam int NS  = 7;
    localparam int SEG = 16;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic [23:0] timeout;
    logic        err_clear;
    logic [2:0]  cur_surf;
    logic        busy;
    logic [15:0] event_count;
    logic        err_to, err_len;

    surf_event_sequencer_if #(.NSURF(NS)) bus();

    surf_event_sequencer #(.NSURF(NS), .SEG_BYTES(SEG), .TIMEOUT_WIDTH(24)) dut (
        .aclk(aclk), .aresetn(aresetn), .dout(bus),
        .timeout_i(timeout), .err_clear_i(err_clear),
        .cur_surf_o(cur_surf), .busy_o(busy), .event_count_o(event_count),
        .err_timeout_o(err_to), .err_length_o(err_len)
    );

    always #5 aclk = ~aclk;

    int          len [NS];
    int          pos [NS];
    logic [NS-1:0] stall = '0;
    logic        start = 1'b0;

    function automatic logic [7:0] pat(input int s, input int p);
        return 8'(s * 37 + p * 3 + 1);
    endfunction

    // Source models: each SURF offers len[i] bytes once per start pulse.
    always @(posedge aclk) begin
        for (int i = 0; i < NS; i++) begin
            if (!aresetn)   pos[i] <= len[i];
            else if (start) pos[i] <= 0;
            else if (bus.s_dout_tvalid[i] && bus.s_dout_tready[i]) pos[i] <= pos[i] + 1;
        end
    end

    always_comb begin
        bus.s_dout_tvalid = '0;
        bus.s_dout_tlast  = '0;
        bus.s_dout_tdata  = '0;
        for (int i = 0; i < NS; i++) begin
            bus.s_dout_tvalid[i]       = (pos[i] < len[i]) && !stall[i];
            bus.s_dout_tlast[i]        = (pos[i] == len[i] - 1);
            bus.s_dout_tdata[8*i +: 8] = pat(i, pos[i]);
        end
    end

    int   checks = 0;
    int   errors = 0;
    int   t_surf, t_pos, nbytes;
    logic saw_last;
    logic rand_rdy = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One cycle: optionally re-randomise ready after the edge, then check at the negedge.
    task automatic step();
        logic [NS-1:0] others;
        @(posedge aclk);
        #1;
        if (rand_rdy) bus.m_dout_tready = 1'($urandom_range(0, 1));
        @(negedge aclk);
        others = bus.s_dout_tready & ~(NS'(1) << cur_surf);
        chk("tready_only_sel", 32'(others), 32'd0);
        if (bus.m_dout_tvalid && bus.m_dout_tready) begin
            chk("cur_surf", 32'(cur_surf), 32'(t_surf));
            chk("data", 32'(bus.m_dout_tdata), 32'(pat(t_surf, t_pos)));
            chk("tlast", 32'(bus.m_dout_tlast), 32'(t_surf == NS - 1 && t_pos == len[t_surf] - 1));
            if (bus.m_dout_tlast) saw_last = 1'b1;
            nbytes++;
            if (t_pos == len[t_surf] - 1) begin
                t_pos  = 0;
                t_surf = (t_surf == NS - 1) ? 0 : t_surf + 1;
            end else begin
                t_pos++;
            end
        end
    endtask

    task automatic load(input int short_surf, input int short_len);
        stall = '1;
        for (int i = 0; i < NS; i++) len[i] = SEG;
        if (short_surf >= 0) len[short_surf] = short_len;
        t_surf = 0; t_pos = 0; nbytes = 0; saw_last = 1'b0;
        @(posedge aclk); #1 start = 1'b1;
        @(posedge aclk); #1 start = 1'b0;
        stall = '0;
    endtask

    task automatic wait_pos(input int s, input int p);
        for (int i = 0; i < 1000 && pos[s] != p; i++) step();
        chk("reach_pos", 32'(pos[s]), 32'(p));
    endtask

    task automatic run_to_end(input logic [15:0] exp_cnt);
        for (int i = 0; i < 2000 && !saw_last; i++) step();
        chk("event_end_seen", 32'(saw_last), 32'd1);
        chk("count_at_last", 32'(event_count), 32'(16'(exp_cnt - 16'd1)));
        step();
        chk("busy_in_done", 32'(busy), 32'd1);
        chk("count_in_done", 32'(event_count), 32'(16'(exp_cnt - 16'd1)));
        step();
        chk("count_after", 32'(event_count), 32'(exp_cnt));
        chk("busy_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        aresetn = 1'b0; timeout = '0; err_clear = 1'b0;
        bus.m_dout_tready = 1'b1;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_sel", 32'(cur_surf), 0);
        chk("rst_count", 32'(event_count), 0);
        chk("rst_errs", 32'({err_to, err_len}), 0);
        chk("rst_mvalid", 32'(bus.m_dout_tvalid), 0);
        chk("rst_tready", 32'(bus.s_dout_tready), 0);
        aresetn = 1'b1;

        // Full event, ready always high.
        load(-1, 0);
        run_to_end(16'd1);
        chk("A_bytes", 32'(nbytes), NS * SEG);
        chk("A_errs", 32'({err_to, err_len}), 0);

        // Same event under random backpressure.
        rand_rdy = 1'b1;
        load(-1, 0);
        run_to_end(16'd2);
        chk("B_bytes", 32'(nbytes), NS * SEG);
        chk("B_errs", 32'({err_to, err_len}), 0);
        rand_rdy = 1'b0;
        bus.m_dout_tready = 1'b1;

        // SURF 3 one byte short.
        load(3, SEG - 1);
        wait_pos(3, SEG - 2);
        chk("C_len_before", 32'(err_len), 0);
        wait_pos(3, SEG - 1);
        chk("C_len_set", 32'(err_len), 1);
        run_to_end(16'd3);
        chk("C_bytes", 32'(nbytes), NS * SEG - 1);
        err_clear = 1'b1;
        step();
        chk("C_len_cleared", 32'(err_len), 0);
        err_clear = 1'b0;

        // SURF 5 one byte long: flagged when count reaches SEG without tlast.
        load(5, SEG + 1);
        wait_pos(5, SEG - 1);
        chk("D_len_before", 32'(err_len), 0);
        wait_pos(5, SEG);
        chk("D_len_at_seg", 32'(err_len), 1);
        run_to_end(16'd4);
        chk("D_bytes", 32'(nbytes), NS * SEG + 1);
        err_clear = 1'b1;
        step();
        err_clear = 1'b0;
        chk("D_len_cleared", 32'(err_len), 0);

        // Stall on SURF 2 with timeout 100.
        timeout = 24'd100;
        load(-1, 0);
        wait_pos(2, 5);
        stall[2] = 1'b1;
        repeat (99) step();
        chk("E_to_99", 32'(err_to), 0);
        step();
        chk("E_to_100", 32'(err_to), 1);
        repeat (50) step();
        chk("E_to_held", 32'(err_to), 1);
        chk("E_sel_held", 32'(cur_surf), 2);
        stall[2] = 1'b0;
        run_to_end(16'd5);
        chk("E_bytes", 32'(nbytes), NS * SEG);
        chk("E_len", 32'(err_len), 0);
        err_clear = 1'b1;
        step();
        err_clear = 1'b0;
        chk("E_to_cleared", 32'(err_to), 0);

        // Same stall with timeout disabled.
        timeout = '0;
        load(-1, 0);
        wait_pos(2, 5);
        stall[2] = 1'b1;
        repeat (150) step();
        chk("F_to_off", 32'(err_to), 0);
        stall[2] = 1'b0;
        run_to_end(16'd6);
        chk("F_bytes", 32'(nbytes), NS * SEG);

        // Reset while SURF 4 is mid-segment, with a length error pending.
        load(1, SEG - 1);
        wait_pos(4, 6);
        chk("H_len_pre", 32'(err_len), 1);
        chk("H_sel_pre", 32'(cur_surf), 4);
        aresetn = 1'b0;
        step();
        chk("H_sel", 32'(cur_surf), 0);
        chk("H_busy", 32'(busy), 0);
        chk("H_count", 32'(event_count), 0);
        chk("H_errs", 32'({err_to, err_len}), 0);
        chk("H_mvalid", 32'(bus.m_dout_tvalid), 0);
        chk("H_tready", 32'(bus.s_dout_tready), 0);
        aresetn = 1'b1;

        // Event counter wrap.
        force dut.event_cnt = 16'hFFFF;
        #1;
        release dut.event_cnt;
        chk("G_count_max", 32'(event_count), 32'hFFFF);
        load(-1, 0);
        run_to_end(16'd0);
        chk("G_bytes", 32'(nbytes), NS * SEG);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
